// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the 6116 SRAM sequencer/arbiter:
//   - ADDR_W / DATA_W : SRAM address and data widths (2K x 8)
//   - CNT_W           : width of the pulse-width down-counter
//   - ST_*            : state encodings, wrapped by state_e
//   - strobe_t        : registered SRAM pin strobes
//   - strobes_for()   : pin levels that belong to each state
package sram_arb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_RD       = ST_RD,
        S_WR_SETUP = ST_WR_SETUP,
        S_WR_PULSE = ST_WR_PULSE,
        S_WR_HOLD  = ST_WR_HOLD
    } state_e;

    typedef struct packed {
        logic csb;
        logic web;
        logic oeb;
        logic dq_oe;
    } strobe_t;

    // Pin levels are a pure function of the state being entered, so the
    // strobes can be registered alongside the state and never glitch.
    // OEb is only ever low in S_RD, where the pad driver is off.
    function automatic strobe_t strobes_for(input state_e st);
        strobe_t s;
        s = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, dq_oe: 1'b0};
        case (st)
            S_RD:       s = '{csb: 1'b0, web: 1'b1, oeb: 1'b0, dq_oe: 1'b0};
            S_WR_SETUP: s = '{csb: 1'b0, web: 1'b1, oeb: 1'b1, dq_oe: 1'b1};
            S_WR_PULSE: s = '{csb: 1'b0, web: 1'b0, oeb: 1'b1, dq_oe: 1'b1};
            S_WR_HOLD:  s = '{csb: 1'b0, web: 1'b1, oeb: 1'b1, dq_oe: 1'b1};
            default:    s = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, dq_oe: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant
//   Combinational winner select between port A and port B.
//   Ports:
//     a_req, b_req   : pending requests
//     a_ack, b_ack   : registered acks; a port acked this cycle is masked
//                      because its req is still high until it sees the ack
//     ptr_b          : (RR_ARB_EN only) 1 = B has priority on contention
//     grant_valid    : some eligible port is requesting
//     grant_b        : 1 = B wins, 0 = A wins (valid with grant_valid)
//   Build option: RR_ARB_EN selects round-robin; otherwise A has fixed priority.
module sram_arb_grant (
    input  logic a_req,
    input  logic b_req,
    input  logic a_ack,
    input  logic b_ack,
`ifdef RR_ARB_EN
    input  logic ptr_b,
`endif
    output logic grant_valid,
    output logic grant_b
);

    logic a_elig;
    logic b_elig;

    always_comb begin
        a_elig      = a_req & ~a_ack;
        b_elig      = b_req & ~b_ack;
        grant_valid = a_elig | b_elig;
`ifdef RR_ARB_EN
        grant_b     = b_elig & (~a_elig | ptr_b);
`else
        grant_b     = b_elig & ~a_elig;
`endif
    end

endmodule

// File: rtl/sram6116_arbiter.sv
// sram6116_arbiter
//   Two-port arbiter and cycle sequencer for a 6116-type 2K x 8 async SRAM.
//   Parameters:
//     RD_WAIT  : cycles CSb/OEb are low per read (1..15)
//     WR_PULSE : cycles WEb is low per write (1..15)
//   Ports:
//     clk, rst                 : clock; asynchronous active-high reset
//     a_* / b_*                : requester ports (req/we/addr/wdata in,
//                                ack pulse and held rdata out)
//     busy                     : transaction in progress
//     sram_csb/web/oeb, sram_a : registered SRAM pins
//     sram_dq_o, sram_dq_oe    : write data and drive enable to pad buffer
//     sram_dq_i                : read data from pad buffer
//   Build option: RR_ARB_EN enables round-robin arbitration (see sram_arb_grant).
import sram_arb_pkg::*;

module sram6116_arbiter #(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i
);

    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_PULSE - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_b_q, sel_b_d;
    strobe_t           strb_q, strb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              grant_valid;
    logic              grant_b;
`ifdef RR_ARB_EN
    logic              ptr_b_q, ptr_b_d;
`endif

    sram_arb_grant u_grant (
        .a_req       (a_req),
        .b_req       (b_req),
        .a_ack       (a_ack_q),
        .b_ack       (b_ack_q),
`ifdef RR_ARB_EN
        .ptr_b       (ptr_b_q),
`endif
        .grant_valid (grant_valid),
        .grant_b     (grant_b)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_b_d   = sel_b_q;
        addr_d    = addr_q;
        dq_o_d    = dq_o_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifdef RR_ARB_EN
        ptr_b_d   = ptr_b_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    // Address and write data are latched only here, so they
                    // stay constant for the whole SRAM cycle.
                    sel_b_d = grant_b;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    dq_o_d  = grant_b ? b_wdata : a_wdata;
`ifdef RR_ARB_EN
                    // Priority passes to the port that was not just granted.
                    ptr_b_d = ~grant_b;
`endif
                    if (grant_b ? b_we : a_we) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = RD_CNT_INIT;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    if (sel_b_q) begin
                        b_rdata_d = sram_dq_i;
                        b_ack_d   = 1'b1;
                    end else begin
                        a_rdata_d = sram_dq_i;
                        a_ack_d   = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WR_CNT_INIT;
            end
            S_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                a_ack_d = ~sel_b_q;
                b_ack_d = sel_b_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        strb_d = strobes_for(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_b_q   <= 1'b0;
            strb_q    <= '{csb: 1'b1, web: 1'b1, oeb: 1'b1, dq_oe: 1'b0};
            addr_q    <= '0;
            dq_o_q    <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifdef RR_ARB_EN
            ptr_b_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_b_q   <= sel_b_d;
            strb_q    <= strb_d;
            addr_q    <= addr_d;
            dq_o_q    <= dq_o_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifdef RR_ARB_EN
            ptr_b_q   <= ptr_b_d;
`endif
        end
    end

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign busy       = (state_q != S_IDLE);
    assign sram_csb   = strb_q.csb;
    assign sram_web   = strb_q.web;
    assign sram_oeb   = strb_q.oeb;
    assign sram_dq_oe = strb_q.dq_oe;
    assign sram_a     = addr_q;
    assign sram_dq_o  = dq_o_q;

endmodule

// File: tb/tb_sram6116_arbiter.sv
// tb_sram6116_arbiter
//   Directed bench for sram6116_arbiter with a behavioural 6116 model.
module tb_sram6116_arbiter;

    localparam int RD_W = 2;
    localparam int WR_P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [10:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack, busy;
    logic [7:0]  a_rdata, b_rdata;
    logic        sram_csb, sram_web, sram_oeb, sram_dq_oe;
    logic [10:0] sram_a;
    logic [7:0]  sram_dq_o, sram_dq_i;

    logic [7:0]  mem [0:2047];

    int checks = 0;
    int errors = 0;
    int web_low = 0, csb_low = 0, oe_high = 0, oeb_low = 0, conflicts = 0;

    always #5 clk = ~clk;

    sram6116_arbiter #(.RD_WAIT(RD_W), .WR_PULSE(WR_P)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_ack      (a_ack),
        .a_rdata    (a_rdata),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_ack      (b_ack),
        .b_rdata    (b_rdata),
        .busy       (busy),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_oeb   (sram_oeb),
        .sram_a     (sram_a),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i)
    );

    // 6116 model: output enabled by CSb&OEb low, write committed on WEb rise.
    assign sram_dq_i = (!sram_csb && !sram_oeb) ? mem[sram_a] : 8'hxx;

    always @(posedge sram_web) begin
        if (!rst && !sram_csb) mem[sram_a] = sram_dq_o;
    end

    always @(negedge clk) begin
        if (!sram_web)              web_low++;
        if (!sram_csb)              csb_low++;
        if (sram_dq_oe)             oe_high++;
        if (!sram_oeb)              oeb_low++;
        if (!sram_oeb && sram_dq_oe) conflicts++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        web_low = 0; csb_low = 0; oe_high = 0; oeb_low = 0;
    endtask

    // One request on one port; lat = cycles from the cycle req is seen to ack.
    task automatic xact(input bit pb, input bit we, input logic [10:0] addr,
                        input logic [7:0] wd, output int lat, output logic [7:0] rd);
        @(negedge clk);
        if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(pb ? b_ack : a_ack) && lat < 40);
        rd = pb ? b_rdata : a_rdata;
        a_req = 1'b0;
        b_req = 1'b0;
        $display("xact port=%s we=%0d addr=%03h wdata=%02h lat=%0d rdata=%02h",
                 pb ? "B" : "A", we, addr, wd, lat, rd);
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          a_cyc, b_cyc;
        logic [7:0]  rd, a_val, b_val;
        bit          a_done, b_done, first_b, seen, ack_seen;
        bit          exp_first_b;

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", {28'h0, sram_csb, sram_web, sram_oeb, sram_dq_oe}, 32'hE);
        rst = 1'b0;
        @(negedge clk);
        check("reset_bus", {13'h0, sram_a, sram_dq_o}, 32'h0);
        check("reset_ports", {a_ack, b_ack, a_rdata, b_rdata, busy}, 32'h0);

        // Write then read on A
        xact(1'b0, 1'b1, 11'h123, 8'h5A, lat, rd);
        check("a_wr_lat", lat, WR_P + 3);
        xact(1'b0, 1'b0, 11'h123, 8'h00, lat, rd);
        check("a_rd_lat", lat, RD_W + 1);
        check("a_rd_data", rd, 8'h5A);

        // Write on B with strobe pulse-width accounting
        clear_counts();
        xact(1'b1, 1'b1, 11'h7FF, 8'hC3, lat, rd);
        check("b_wr_lat", lat, WR_P + 3);
        check("b_wr_web_low", web_low, WR_P);
        check("b_wr_csb_low", csb_low, WR_P + 2);
        check("b_wr_oe_high", oe_high, WR_P + 2);
        check("b_wr_oeb_low", oeb_low, 0);
        check("b_wr_mem", mem[11'h7FF], 8'hC3);

        // Seed 0x010, then leave B as the last-granted port
        xact(1'b0, 1'b1, 11'h010, 8'h11, lat, rd);
        xact(1'b1, 1'b0, 11'h7FF, 8'h00, lat, rd);
        check("b_rd_data", rd, 8'hC3);

        // A read and B write to the same address requested together
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
        b_req = 1'b1; b_we = 1'b1; b_addr = 11'h010; b_wdata = 8'h99;
        a_done = 1'b0; b_done = 1'b0; a_cyc = 0; b_cyc = 0; a_val = 8'h00; cyc = 0;
        while (!(a_done && b_done) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack && !a_done) begin a_done = 1'b1; a_cyc = cyc; a_val = a_rdata; a_req = 1'b0; end
            if (b_ack && !b_done) begin b_done = 1'b1; b_cyc = cyc; b_req = 1'b0; end
        end
        $display("queued a_cyc=%0d b_cyc=%0d a_rdata=%02h", a_cyc, b_cyc, a_val);
        check("queued_done", {30'h0, a_done, b_done}, 32'h3);
        check("queued_a_old", a_val, 8'h11);
        check("queued_a_lat", a_cyc, RD_W + 1);
        check("queued_b_lat", b_cyc, RD_W + 1 + WR_P + 3);
        @(posedge clk); #1;
        xact(1'b0, 1'b0, 11'h010, 8'h00, lat, rd);
        check("queued_a_new", rd, 8'h99);

        // Contention from a clean IDLE cycle; A was granted last
`ifdef RR_ARB_EN
        exp_first_b = 1'b1;
`else
        exp_first_b = 1'b0;
`endif
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h123;
        b_req = 1'b1; b_we = 1'b0; b_addr = 11'h7FF;
        a_done = 1'b0; b_done = 1'b0; first_b = 1'b0; a_val = 8'h00; b_val = 8'h00; cyc = 0;
        while (!(a_done && b_done) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack && !a_done) begin a_done = 1'b1; a_val = a_rdata; a_req = 1'b0; end
            if (b_ack && !b_done) begin first_b = !a_done; b_done = 1'b1; b_val = b_rdata; b_req = 1'b0; end
        end
        $display("contention first=%s a_rdata=%02h b_rdata=%02h", first_b ? "B" : "A", a_val, b_val);
        check("policy_first", first_b, exp_first_b);
        check("policy_rdata", {16'h0, a_val, b_val}, 32'h5AC3);
        @(posedge clk); #1;

        // Reset during the write pulse
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 11'h200; a_wdata = 8'h77;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = !sram_web;
        end
        check("rst_reached_pulse", seen, 1'b1);
        #2 rst = 1'b1;
        #1;
        $display("reset mid-write csb=%0d web=%0d oeb=%0d oe=%0d busy=%0d",
                 sram_csb, sram_web, sram_oeb, sram_dq_oe, busy);
        check("rst_strobes", {28'h0, sram_csb, sram_web, sram_oeb, sram_dq_oe}, 32'hE);
        check("rst_busy", busy, 1'b0);
        a_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ack_seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | a_ack | b_ack;
        end
        check("rst_no_ack", ack_seen, 1'b0);
        xact(1'b1, 1'b0, 11'h123, 8'h00, lat, rd);
        check("post_rst_lat", lat, RD_W + 1);
        check("post_rst_data", rd, 8'h5A);

        check("oe_conflicts", conflicts, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
